// File: rtl/shift_seq_8_bit.sv
// Multi-cycle logical shifter: moves an operand left or right one bit per clock,
// with a start/busy/done handshake for the ALU sequencer.
`timescale 1ns/1ps
module shift_seq_8_bit #(
    parameter int WIDTH = 8,
    parameter int AMT_W = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             dir,
    input  logic [AMT_W-1:0] amount,
    input  logic [WIDTH-1:0] d_in,
    input  logic             fill,
    output logic [WIDTH-1:0] result,
    output logic             carry_out,
    output logic             busy,
    output logic             done
);

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        DONE
    } state_t;

    state_t           state;
    state_t           next_state;
    logic [AMT_W-1:0] count;
    logic             dir_q;
    logic             fill_q;
    logic             load;
    logic             step;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // A new operation may load from IDLE or straight out of DONE (back-to-back).
    always_comb begin
        next_state = state;
        load       = 1'b0;
        step       = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    load       = 1'b1;
                    next_state = (amount == '0) ? DONE : SHIFT;
                end
            end
            SHIFT: begin
                step = 1'b1;
                if (count == AMT_W'(1)) begin
                    next_state = DONE;
                end
            end
            DONE: begin
                if (start) begin
                    load       = 1'b1;
                    next_state = (amount == '0) ? DONE : SHIFT;
                end else begin
                    next_state = IDLE;
                end
            end
            default: begin
                next_state = IDLE;
            end
        endcase
    end

    // Direction and fill are captured at load so the sequencer may change its inputs mid-shift.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            result    <= '0;
            carry_out <= 1'b0;
            count     <= '0;
            dir_q     <= 1'b0;
            fill_q    <= 1'b0;
        end else if (load) begin
            result    <= d_in;
            carry_out <= 1'b0;
            count     <= amount;
            dir_q     <= dir;
            fill_q    <= fill;
        end else if (step) begin
            if (dir_q) begin
                carry_out <= result[0];
                result    <= {fill_q, result[WIDTH-1:1]};
            end else begin
                carry_out <= result[WIDTH-1];
                result    <= {result[WIDTH-2:0], fill_q};
            end
            count <= count - AMT_W'(1);
        end
    end

    assign busy = (state == SHIFT);
    assign done = (state == DONE);

endmodule

// File: tb/tb_shift_seq_8_bit.sv
// Scenario bench for shift_seq_8_bit: expected results are queued at start and
// compared by a monitor whenever done pulses.
`timescale 1ns/1ps
module tb_shift_seq_8_bit;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic       dir;
    logic [2:0] amount;
    logic [7:0] d_in;
    logic       fill;
    logic [7:0] result;
    logic       carry_out;
    logic       busy;
    logic       done;

    typedef struct {
        logic [7:0] res;
        logic       co;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int   checks = 0;
    int   errors = 0;

    shift_seq_8_bit #(.WIDTH(8), .AMT_W(3)) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .dir      (dir),
        .amount   (amount),
        .d_in     (d_in),
        .fill     (fill),
        .result   (result),
        .carry_out(carry_out),
        .busy     (busy),
        .done     (done)
    );

    always #5 clk = ~clk;

    // Reference shift: one bit at a time, carry is the last bit pushed out.
    function automatic exp_t model(input logic [7:0] d, input logic dr, input logic [2:0] a,
                                   input logic f);
        exp_t e;
        e.res = d;
        e.co  = 1'b0;
        for (int i = 0; i < int'(a); i++) begin
            if (dr) begin
                e.co  = e.res[0];
                e.res = {f, e.res[7:1]};
            end else begin
                e.co  = e.res[7];
                e.res = {e.res[6:0], f};
            end
        end
        return e;
    endfunction

    // Monitor: every done pulse must match the oldest outstanding operation.
    always @(negedge clk) begin
        if (!rst && done === 1'b1) begin
            checks++;
            if (sb.size() == 0) begin
                errors++;
                $display("[TB] FAIL unexpected_done: done=1 with no operation pending");
            end else begin
                mon_e = sb.pop_front();
                if (result !== mon_e.res) begin
                    errors++;
                    $display("[TB] FAIL sb_result: got %b expected %b", result, mon_e.res);
                end
                checks++;
                if (carry_out !== mon_e.co) begin
                    errors++;
                    $display("[TB] FAIL sb_carry: got %b expected %b", carry_out, mon_e.co);
                end
            end
        end
    end

    // Drives one start edge, then scrambles the inputs to prove they were latched.
    task automatic start_op(input logic [7:0] d, input logic dr, input logic [2:0] a,
                            input logic f);
        d_in   = d;
        dir    = dr;
        amount = a;
        fill   = f;
        start  = 1'b1;
        sb.push_back(model(d, dr, a, f));
        @(posedge clk);
        #1;
        start  = 1'b0;
        d_in   = ~d;
        dir    = ~dr;
        amount = a + 3'd2;
        fill   = ~f;
    endtask

    task automatic wait_done(output int k, output int bc, output int overlap);
        k       = 0;
        bc      = 0;
        overlap = 0;
        do begin
            @(negedge clk);
            k++;
            if (busy === 1'b1) bc++;
            if (busy === 1'b1 && done === 1'b1) overlap++;
        end while (done !== 1'b1 && k < 40);
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b0; dir = 1'b0; amount = '0; d_in = '0; fill = 1'b0;
        repeat (2) @(negedge clk);
        checks++;
        if ({result, carry_out, busy, done} !== 11'b0) begin
            errors++;
            $display("[TB] FAIL reset_outputs: got %b expected %b", {result, carry_out, busy, done}, 11'b0);
        end
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_left();
        int k, bc, ov;
        start_op(8'b1011_0010, 1'b0, 3'd3, 1'b0);
        wait_done(k, bc, ov);
        checks++;
        if (k !== 4) begin errors++; $display("[TB] FAIL left_latency: got %0d expected %0d", k, 4); end
        checks++;
        if (bc !== 3) begin errors++; $display("[TB] FAIL left_busy_cycles: got %0d expected %0d", bc, 3); end
        checks++;
        if (ov !== 0) begin errors++; $display("[TB] FAIL left_busy_done_overlap: got %0d expected %0d", ov, 0); end
        @(negedge clk);
        checks++;
        if ({busy, done} !== 2'b00) begin
            errors++; $display("[TB] FAIL left_idle_flags: got %b expected %b", {busy, done}, 2'b00);
        end
        checks++;
        if ({result, carry_out} !== {8'b1001_0000, 1'b1}) begin
            errors++; $display("[TB] FAIL left_held: got %b expected %b", {result, carry_out}, {8'b1001_0000, 1'b1});
        end
    endtask

    task automatic test_right();
        int k, bc, ov;
        start_op(8'b1011_0010, 1'b1, 3'd2, 1'b1);
        wait_done(k, bc, ov);
        checks++;
        if (k !== 3) begin errors++; $display("[TB] FAIL right_latency: got %0d expected %0d", k, 3); end
        checks++;
        if (bc !== 2) begin errors++; $display("[TB] FAIL right_busy_cycles: got %0d expected %0d", bc, 2); end
        @(negedge clk);
    endtask

    task automatic test_zero_amount();
        int k, bc, ov;
        start_op(8'h5A, 1'b0, 3'd0, 1'b1);
        wait_done(k, bc, ov);
        checks++;
        if (k !== 1) begin errors++; $display("[TB] FAIL zero_latency: got %0d expected %0d", k, 1); end
        checks++;
        if (bc !== 0) begin errors++; $display("[TB] FAIL zero_busy_cycles: got %0d expected %0d", bc, 0); end
        @(negedge clk);
        checks++;
        if ({result, carry_out} !== {8'h5A, 1'b0}) begin
            errors++; $display("[TB] FAIL zero_held: got %b expected %b", {result, carry_out}, {8'h5A, 1'b0});
        end
    endtask

    task automatic test_max_amount();
        int k, bc, ov;
        start_op(8'b0000_0001, 1'b0, 3'd7, 1'b1);
        wait_done(k, bc, ov);
        checks++;
        if (k !== 8) begin errors++; $display("[TB] FAIL max_latency: got %0d expected %0d", k, 8); end
        checks++;
        if (bc !== 7) begin errors++; $display("[TB] FAIL max_busy_cycles: got %0d expected %0d", bc, 7); end
        @(negedge clk);
    endtask

    task automatic test_start_while_busy();
        int k, bc, ov;
        start_op(8'h3C, 1'b0, 3'd4, 1'b0);
        @(negedge clk);
        @(negedge clk);
        d_in = 8'hFF; amount = 3'd1; start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        wait_done(k, bc, ov);
        checks++;
        if (k !== 3) begin errors++; $display("[TB] FAIL busy_start_latency: got %0d expected %0d", k, 3); end
        @(negedge clk);
        checks++;
        if ({busy, done} !== 2'b00) begin
            errors++; $display("[TB] FAIL busy_start_idle: got %b expected %b", {busy, done}, 2'b00);
        end
    endtask

    task automatic test_back_to_back();
        int k, bc, ov;
        start_op(8'hA5, 1'b1, 3'd2, 1'b0);
        wait_done(k, bc, ov);
        checks++;
        if (k !== 3) begin errors++; $display("[TB] FAIL b2b_first_latency: got %0d expected %0d", k, 3); end
        start_op(8'h0F, 1'b0, 3'd3, 1'b1);
        @(negedge clk);
        checks++;
        if (busy !== 1'b1) begin errors++; $display("[TB] FAIL b2b_no_gap: got busy=%b expected busy=%b", busy, 1'b1); end
        wait_done(k, bc, ov);
        checks++;
        if (k !== 3) begin errors++; $display("[TB] FAIL b2b_second_latency: got %0d expected %0d", k, 3); end
        @(negedge clk);
    endtask

    task automatic test_reset_abort();
        int k, bc, ov;
        int seen;
        start_op(8'hC3, 1'b0, 3'd5, 1'b0);
        @(negedge clk);
        @(negedge clk);
        #2 rst = 1'b1;
        #1;
        checks++;
        if ({result, carry_out, busy, done} !== 11'b0) begin
            errors++;
            $display("[TB] FAIL abort_outputs: got %b expected %b", {result, carry_out, busy, done}, 11'b0);
        end
        sb.delete();
        @(negedge clk);
        rst  = 1'b0;
        seen = 0;
        repeat (8) begin
            @(negedge clk);
            if (done === 1'b1 || busy === 1'b1) seen++;
        end
        checks++;
        if (seen !== 0) begin errors++; $display("[TB] FAIL abort_activity: got %0d expected %0d", seen, 0); end
        start_op(8'h81, 1'b1, 3'd1, 1'b0);
        wait_done(k, bc, ov);
        checks++;
        if (k !== 2) begin errors++; $display("[TB] FAIL post_abort_latency: got %0d expected %0d", k, 2); end
        @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        test_reset();
        test_left();
        test_right();
        test_zero_amount();
        test_max_amount();
        test_start_while_busy();
        test_back_to_back();
        test_reset_abort();
        checks++;
        if (sb.size() !== 0) begin
            errors++; $display("[TB] FAIL sb_leftover: got %0d expected %0d", sb.size(), 0);
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/shift_seq_8_bit.md
Name: shift_seq_8_bit

Overview:
- Multi-cycle 8-bit shift unit for the ALU. Shifts an operand left or right by 0-7 positions, one bit position per clock.
- It is the iterative counterpart of the single-step 8-bit shifter: it drives shift direction and shift-in, and collects the bit-bucket output as carry_out.
- Used by the ALU sequencer for variable-amount shift instructions, with a start/busy/done handshake.

Parameters:
- WIDTH, 8, datapath width. Only 8 is verified.
- AMT_W, 3, width of the shift-amount field. Must equal log2(WIDTH).

Ports:
- clk  input  1  system clock, rising-edge active
- rst  input  1  reset, asynchronous, active-high
- start  input  1  request a shift operation; sampled on rising clk
- dir  input  1  0 = shift left, 1 = shift right (same encoding as the single-step shifter select)
- amount  input  AMT_W  number of bit positions to shift, 0-7
- d_in  input  WIDTH  operand
- fill  input  1  bit shifted into the vacated end on every step
- result  output  WIDTH  shifted value; held until the next accepted start
- carry_out  output  1  last bit shifted out (bit bucket of the final step)
- busy  output  1  high while shifting
- done  output  1  one-cycle pulse; result and carry_out are valid

Behaviour:
- Reset (asynchronous, takes effect immediately, overrides everything):
  - state = IDLE
  - result, carry_out, busy, done = 0
  - internal count = 0
- States: IDLE, SHIFT, DONE.
- Start acceptance:
  - start is accepted only in IDLE or DONE.
  - start is ignored in SHIFT; the operation in flight is not disturbed.
- On an accepted start (edge E0), latch:
  - result <= d_in
  - count <= amount
  - dir and fill into internal registers; input changes after E0 have no effect
  - carry_out <= 0
- State after E0:
  - amount == 0: go to DONE.
  - otherwise: go to SHIFT, busy = 1.
- SHIFT, on each edge:
  - Left: carry_out <= result[7]; result <= {result[6:0], fill_latched}.
  - Right: carry_out <= result[0]; result <= {fill_latched, result[7:1]}.
  - count decrements. When the step that brings count to 0 completes, go to DONE and deassert busy.
- DONE:
  - Lasts exactly one cycle with done = 1, busy = 0.
  - Then IDLE, unless start is asserted, in which case a new operation loads at that edge (back-to-back).
- Latency:
  - done goes high N edges after E0, where N = amount.
  - For amount = 0, done goes high right after E0 (1-cycle latency).
  - busy is high for exactly N cycles and never for amount = 0.
- busy and done are mutually exclusive.
- result and carry_out change only on load or shift steps. They are stable in IDLE and DONE.
- Arithmetic: logical shift with an explicit fill bit; no sign extension or rotate beyond what fill provides.
- Reset in SHIFT aborts the operation; no done pulse is emitted for the aborted operation.

Test Plan:
- Left shift: d_in = 1011_0010, dir = 0, amount = 3, fill = 0 → busy high 3 cycles; done pulse; result = 1001_0000, carry_out = 1.
- Right shift: d_in = 1011_0010, dir = 1, amount = 2, fill = 1 → result = 1110_1100, carry_out = 1, done 2 edges after start.
- Zero amount: d_in = 0x5A, amount = 0 → done high in the cycle after the start edge; busy never high; result = 0x5A, carry_out = 0.
- Maximum amount with fill: d_in = 0000_0001, dir = 0, amount = 7, fill = 1 → busy 7 cycles; result = 1111_1111, carry_out = 0.
- Start while busy, plus back-to-back start:
  - First op: amount = 4 left; re-assert start with d_in = 0xFF in cycle 2 → ignored; result matches the first operation only.
  - start asserted during the DONE cycle → new operation loads with no IDLE gap.
- Reset mid-operation: assert rst asynchronously (between edges) during SHIFT → result, carry_out, busy and done go to 0 immediately; no done pulse; a subsequent start operates normally.
